// File: rtl/calc_pkg.sv
// Shared types and key constants for the keypad injector and its testbenches.
// Key index layout: row in bits [3:2], column in bits [1:0].
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } inj_state_t;

  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_ADD  = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_SUB  = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_MULT = 4'd11;
  localparam logic [3:0] KEY_EQ   = 4'd12;
  localparam logic [3:0] KEY_NEG  = 4'd15;

  function automatic logic [1:0] key_row(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] idx);
    return idx[1:0];
  endfunction

endpackage

// File: rtl/keypad_injector.sv
// Emulates a keypad closure: pulls the key's row low only while its column is strobed.
// One request at a time (key_ready low while busy); row_drive has zero lag from col_scan.
module keypad_injector
  import calc_pkg::*;
#(
  parameter int HOLD_SCANS     = 4,
  parameter int RELEASE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       key_valid,
  input  logic [3:0] key_index,
  output logic       key_ready,
  input  logic [3:0] col_scan,
  output logic [3:0] row_drive,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int VW = $clog2(HOLD_SCANS + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [VW-1:0] VISIT_LAST   = VW'(HOLD_SCANS);
  localparam logic [RW-1:0] RELEASE_LAST = RW'(RELEASE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);

  inj_state_t    state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic          match_q, match_d;
  logic [VW-1:0] visit_q, visit_d;
  logic [RW-1:0] rel_q, rel_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          match;
  logic [VW-1:0] visit_inc;
  logic [RW-1:0] rel_inc;
  logic [TW-1:0] timeout_inc;

  // Only the exact one-cold strobe of our column counts as a contact.
  assign match       = (col_scan == ~(4'b0001 << col_q));
  assign visit_inc   = visit_q + VW'(1);
  assign rel_inc     = rel_q + RW'(1);
  assign timeout_inc = timeout_q + TW'(1);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    match_d   = 1'b0;
    visit_d   = visit_q;
    rel_d     = rel_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d   = PRESS;
          row_d     = key_row(key_index);
          col_d     = key_col(key_index);
          visit_d   = '0;
          timeout_d = '0;
        end
      end
      PRESS: begin
        match_d = match;
        // A visit ending in the same cycle as the timeout takes priority.
        if (match_q && !match) begin
          visit_d   = visit_inc;
          timeout_d = '0;
          if (visit_inc == VISIT_LAST) begin
            state_d = RELEASE;
            rel_d   = '0;
          end
        end else if (timeout_inc == TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          timeout_d = timeout_inc;
        end
      end
      RELEASE: begin
        if (rel_inc == RELEASE_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rel_d = rel_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      match_q   <= 1'b0;
      visit_q   <= '0;
      rel_q     <= '0;
      timeout_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      match_q   <= match_d;
      visit_q   <= visit_d;
      rel_q     <= rel_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    row_drive = 4'hF;
    if (nRST && (state_q == PRESS) && match) begin
      row_drive = ~(4'b0001 << row_q);
    end
  end

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/keypad_injector.md
# keypad_injector

Synthesizable keypad-side responder for the 4x4 scanned keypad interface. It receives key indices over a valid/ready handshake and emulates a physical key closure. It watches the calculator's active-low column scan and pulls the matching row low only while the key's column is being driven. It sits between a host/self-test source (UART bridge, BIST sequencer) and `calculator_top`'s `RowIn`/`ColOut` pins, replacing the physical keypad for hardware-in-the-loop testing.

## Interface
- `HOLD_SCANS`, 4: number of complete scan visits to the key's column during which the key is held pressed (1..255).
- `RELEASE_CYCLES`, 64: clock cycles rows stay released after a press before the next key is accepted (1..65535).
- `TIMEOUT_CYCLES`, 1024: cycles allowed without a scan visit to the target column before the press aborts (1..65535).
- `clk  input  1  system clock`
- `nRST  input  1  reset; synchronous, active-low`
- `key_valid  input  1  key request valid`
- `key_index  input  4  key to press; row = key_index[3:2], col = key_index[1:0]`
- `key_ready  output  1  high when a request can be accepted`
- `col_scan  input  4  calculator ColOut; active-low one-cold column strobe`
- `row_drive  output  4  to calculator RowIn; active-low, 4'hF = no key`
- `busy  output  1  a press/release sequence is in progress`
- `done  output  1  one-cycle pulse, sequence completed normally`
- `error  output  1  one-cycle pulse, press aborted on timeout`

## Operation
- States: IDLE, PRESS, RELEASE.
- IDLE: `key_ready`=1, `busy`=0. On `key_valid && key_ready`, latch row/col, clear counters, go to PRESS.
- match = (`col_scan` == ~(4'b0001 << col)). Only an exact one-cold pattern matches; 4'hF or multiple lows never match.
- `row_drive` = ~(4'b0001 << row) when state==PRESS && match && nRST; otherwise 4'hF. This path is combinational from registered state and `col_scan`, giving zero lag, like a real matrix contact.
- PRESS: register match_d each cycle. A visit ends on the falling edge of match (match_d && !match); at that edge, increment visit_cnt.
  - visit_cnt reaching HOLD_SCANS -> RELEASE, with the release counter cleared.
  - timeout_cnt counts cycles and clears at every visit end. If it reaches TIMEOUT_CYCLES: pulse `error`, go directly to IDLE with no RELEASE phase.
- RELEASE: `row_drive`=4'hF. Count RELEASE_CYCLES cycles, then pulse `done` and go to IDLE.
- `key_valid` outside IDLE is ignored and not queued. `key_index` is sampled only at acceptance.
- Counter widths: $clog2(param+1). No wrap is possible because each counter stops at its terminal count.

## Timing
- Reset values: state IDLE, `key_ready`=1, `busy`=0, `done`=0, `error`=0, `row_drive`=4'hF. All counters and match_d are 0.
- Reset mid-operation: `row_drive` is forced to 4'hF combinationally while nRST=0. State returns to IDLE at the reset edge, and no `done`/`error` pulse is issued.
- Acceptance edge: `busy` goes 1 and `key_ready` goes 0 on the next cycle. Rows can be driven from that cycle on.
- A column already active at acceptance is not counted until it first deasserts. match_d starts at 0, so a visit in progress counts only if its falling edge occurs in PRESS.
- `done` is asserted in the single cycle the state returns to IDLE. `key_ready` is 1 in that same cycle, so back-to-back requests are possible.
- Minimum press-to-done latency: 1 + (HOLD_SCANS scan visits) + RELEASE_CYCLES + 1 cycles.
- Visit end and timeout in the same cycle: the visit wins and the timeout clears.

## Structure
- Shared package `calc_pkg` holds:
  - the `inj_state_t` enum (IDLE/PRESS/RELEASE);
  - key index constants KEY_3=2, KEY_ADD=3, KEY_4=4, KEY_5=5, KEY_SUB=7, KEY_7=8, KEY_MULT=11, KEY_EQ=12, KEY_NEG=15;
  - function `key_row(idx)` / `key_col(idx)`.
- Single module; no sub-module is warranted. The three counters and the FSM live in one always_ff block, and `row_drive` is one always_comb.

## Test plan
- Reset, then key_index=KEY_3 (row 0, col 2) with a scanner model cycling columns every 4 cycles -> `row_drive`=4'b1110 only while `col_scan`=4'b1011. Exactly 4 visits are counted, then `done` pulses after 64 release cycles.
- Full calculator loop: inject KEY_NEG, KEY_3, KEY_MULT, KEY_NEG, KEY_4, KEY_EQ into `calculator_top` -> `complete`=1 and `display_output`=12. Repeat with 35*45 -> 1575.
- `col_scan` held at 4'hF after acceptance -> `error` pulses exactly TIMEOUT_CYCLES=1024 cycles later, `row_drive` never leaves 4'hF, and state returns to IDLE.
- `col_scan`=4'b0011 (two columns low) for key col 2 -> no match, `row_drive`=4'hF.
- `key_valid` asserted continuously with a new index during PRESS -> the new index is ignored until `done`. The next key is accepted in the `done` cycle.
- nRST pulled low mid-PRESS while the column matches -> `row_drive`=4'hF in the same cycle and IDLE after the edge, with no `done` or `error` pulse.
